// File: rtl/lsram_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsram_burst_reader_pkg
//  Description : Shared types and constants for the LSRAM burst read path.
//                DATA_WIDTH/ADDR_WIDTH defaults per LSRAM mode are supplied
//                at instantiation (data_width_fn/addr_width_fn).
//  Revision    : 1.0 - initial release
// ============================================================================
package lsram_burst_reader_pkg;

   // Depth of the read-data skid buffer; two entries cover the RAM latency.
   localparam int LSRAM_RD_FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_READ  = 2'd1,
      RD_DRAIN = 2'd2
   } lsram_rd_state_t;

   // A new read may start only if, after this cycle's pop, the words already
   // buffered plus the one in flight leave room in the buffer.
   function automatic logic lsram_rd_can_issue(input logic [1:0] count,
                                               input logic       inflight,
                                               input logic       pop);
      logic [2:0] occ;
      occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      return (occ < 3'(LSRAM_RD_FIFO_DEPTH));
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsram_burst_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsram_burst_reader_if
//  Description : Command, RAM read-port and output stream bundle for the
//                LSRAM burst reader. 'master' is the reader side, 'slave' is
//                the environment (command source, RAM, stream consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsram_burst_reader_if #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 10
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [ADDR_WIDTH-1:0] cmd_len;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  busy;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
      output cmd_ready, ram_addr, m_valid, m_data, m_last, busy
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
      input  cmd_ready, ram_addr, m_valid, m_data, m_last, busy
   );
endinterface
`default_nettype wire

// File: rtl/lsram_rd_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : lsram_rd_fifo2
//  Description : Two-entry first-word-fall-through buffer carrying read data
//                plus a last-beat flag. Head outputs read as zero when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsram_rd_fifo2 #(
   parameter int DATA_WIDTH = 18
) (
   input  wire logic                  aclk,
   input  wire logic                  aresetn,
   input  wire logic                  push,
   input  wire logic [DATA_WIDTH-1:0] push_data,
   input  wire logic                  push_last,
   input  wire logic                  pop,
   input  wire logic                  flush,
   output logic      [DATA_WIDTH-1:0] head_data,
   output logic                       head_last,
   output logic      [1:0]            count
);
   logic [DATA_WIDTH-1:0] r_data [2];
   logic                  r_last [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic                  w_pop;
   logic                  w_push;

   // Pops of an empty buffer and pushes into a full one (without a pop) are
   // dropped so the count can never wrap.
   assign w_pop  = pop && (r_count != 2'd0);
   assign w_push = push && ((r_count != 2'd2) || w_pop);

   // Storage, pointers and occupancy; flush empties without touching storage.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_last[0] <= 1'b0;
         r_last[1] <= 1'b0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else if (flush) begin
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_data[r_wr_ptr] <= push_data;
            r_last[r_wr_ptr] <= push_last;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign head_data = (r_count != 2'd0) ? r_data[r_rd_ptr] : '0;
   assign head_last = (r_count != 2'd0) ? r_last[r_rd_ptr] : 1'b0;
   assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/lsram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : lsram_burst_reader
//  Description : Burst read initiator for an LSRAM read port with 1-cycle
//                registered read latency. Accepts (base, length-1) commands,
//                issues sequential (wrapping) reads and streams the words out
//                on a valid/ready interface with last-beat marking.
//  Options     : LSRAM_BURST_READER_ABORT_EN adds an 'abort' input that
//                truncates the burst in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsram_burst_reader
   import lsram_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 10
) (
   input wire logic aclk,
   input wire logic aresetn,
`ifdef LSRAM_BURST_READER_ABORT_EN
   input wire logic abort,
`endif
   lsram_burst_reader_if.master bus
);
   localparam logic [ADDR_WIDTH-1:0] c_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   lsram_rd_state_t       r_state;
   lsram_rd_state_t       w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_remaining;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic                  w_accept;
   logic                  w_issue;
   logic                  w_flush;
   logic                  w_pop;
   logic                  w_abort;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic                  w_head_last;
   logic [1:0]            w_count;

`ifdef LSRAM_BURST_READER_ABORT_EN
   // Abort only matters while a burst is active; in IDLE it is ignored, so a
   // command handshaking alongside abort is never truncated.
   assign w_abort = abort && (r_state != RD_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   assign w_pop = (w_count != 2'd0) && bus.m_ready;

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= RD_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, command accept, read issue and flush decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (bus.cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RD_READ;
            end
         end
         RD_READ: begin
            if (w_abort) begin
               w_flush     = 1'b1;
               w_state_nxt = RD_IDLE;
            end else if (lsram_rd_can_issue(w_count, r_inflight, w_pop)) begin
               w_issue = 1'b1;
               if (r_remaining == '0) begin
                  w_state_nxt = RD_DRAIN;
               end
            end
         end
         RD_DRAIN: begin
            // The last-flagged word is the final one pushed, so its pop
            // leaves the buffer empty with nothing in flight.
            if (w_abort) begin
               w_flush     = 1'b1;
               w_state_nxt = RD_IDLE;
            end else if (w_pop && w_head_last) begin
               w_state_nxt = RD_IDLE;
            end
         end
         default: begin
            w_state_nxt = RD_IDLE;
         end
      endcase
   end

   // Address counter, remaining count and the in-flight read tracker.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_addr          <= '0;
         r_remaining     <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else if (w_accept) begin
         r_addr          <= bus.cmd_addr;
         r_remaining     <= bus.cmd_len;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else if (w_issue) begin
         r_addr          <= r_addr + c_one;
         r_remaining     <= r_remaining - c_one;
         r_inflight      <= 1'b1;
         r_inflight_last <= (r_remaining == '0);
      end else begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end
   end

   lsram_rd_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push      (r_inflight && !w_flush),
      .push_data (bus.ram_dout),
      .push_last (r_inflight_last),
      .pop       (w_pop),
      .flush     (w_flush),
      .head_data (w_head_data),
      .head_last (w_head_last),
      .count     (w_count)
   );

   // The RAM address is the counter register itself: it holds whenever no
   // read is issued, which keeps the RAM output steady during stalls.
   assign bus.ram_addr  = r_addr;
   assign bus.cmd_ready = (r_state == RD_IDLE);
   assign bus.busy      = (r_state != RD_IDLE);
   assign bus.m_valid   = (w_count != 2'd0);
   assign bus.m_data    = w_head_data;
   assign bus.m_last    = w_head_last;

endmodule
`default_nettype wire
